// File: rtl/pc_seq_pkg.sv
// Shared types for the fetch-stage next-PC controller: FSM states, redirect sources
// ordered by priority, and reset/exception vector defaults.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // Numeric order of the encoding is the redirect priority.
  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_JUMP   = 2'd1,
    SRC_BRANCH = 2'd2,
    SRC_EXC    = 2'd3
  } src_e;

  typedef struct packed {
    src_e        src;
    logic [31:0] tgt;
  } redir_t;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES_DEF  = 32'd4;
  localparam logic [31:0] EXC_VECTOR_DEF   = 32'h8000_0180;

  // A live request at least as urgent as the held one replaces it on consume.
  function automatic logic outranks(input src_e a, input src_e b);
    return (a != SRC_NONE) && (a >= b);
  endfunction

endpackage

// File: rtl/pc_redirect_hold.sv
// Holds the most urgent redirect seen while instruction memory is busy; a strictly
// higher-priority request replaces it, anything else is dropped.
module pc_redirect_hold
  import pc_seq_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   capture_i,
  input  logic   consume_i,
  input  redir_t req_i,
  output redir_t pend_o
);

  redir_t pend_q, pend_d;

  always_comb begin
    pend_d = pend_q;
    if (consume_i)
      pend_d.src = SRC_NONE;
    else if (capture_i && (req_i.src > pend_q.src))
      pend_d = req_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) pend_q <= '{src: SRC_NONE, tgt: '0};
    else       pend_q <= pend_d;
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/pc_sequencer.sv
// Next-address controller for the PC register: sequential / jump / branch / stall
// arbitration with redirects held across instruction-memory busy cycles.
// Optional exception path enabled by defining EXC_VECTOR_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0] INSTR_BYTES  = INSTR_BYTES_DEF
`ifdef EXC_VECTOR_EN
  ,
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF
`endif
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PCResult,
  input  logic        Stall,
  input  logic        ImemReady,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
`ifdef EXC_VECTOR_EN
  input  logic        ExcReq,
  output logic [31:0] EPC,
`endif
  output logic [31:0] Address,
  output logic        FetchValid,
  output logic        FlushIF
);

  state_e state_q, state_d;
  redir_t req, pend, sel;
  logic   active, take;

  always_comb begin
    req = '{src: SRC_NONE, tgt: '0};
    if (Jump)        req = '{src: SRC_JUMP,   tgt: JumpTarget};
    if (BranchTaken) req = '{src: SRC_BRANCH, tgt: BranchTarget};
`ifdef EXC_VECTOR_EN
    if (ExcReq)      req = '{src: SRC_EXC,    tgt: EXC_VECTOR};
`endif
  end

  assign active = !Reset && (state_q != ST_BOOT);
  assign sel    = outranks(req.src, pend.src) ? req : pend;
  assign take   = active && ImemReady && (sel.src != SRC_NONE);

  pc_redirect_hold u_hold (
    .clk_i     (Clk),
    .rst_i     (Reset),
    .capture_i (active && !ImemReady),
    .consume_i (active && ImemReady),
    .req_i     (req),
    .pend_o    (pend)
  );

  // Redirects win over stall; in WAIT only a redirect moves the PC.
  always_comb begin
    Address    = PCResult;
    FetchValid = 1'b0;
    FlushIF    = 1'b0;
    if (!active) begin
      Address = RESET_VECTOR;
    end else if (take) begin
      Address = sel.tgt;
      FlushIF = 1'b1;
    end else if (ImemReady && (state_q == ST_RUN) && !Stall) begin
      Address    = PCResult + INSTR_BYTES;
      FetchValid = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  if (!ImemReady) state_d = ST_WAIT;
      ST_WAIT: if (ImemReady)  state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= ST_BOOT;
    else       state_q <= state_d;
  end

`ifdef EXC_VECTOR_EN
  always_ff @(posedge Clk) begin
    if (Reset)                        EPC <= '0;
    else if (take && sel.src == SRC_EXC) EPC <= PCResult;
  end
`endif

endmodule
